// File: rtl/reg_file_sb.sv
// Multi-port register file with write-first read bypass and a per-register
// busy scoreboard (set at issue, cleared at writeback, cleared all on flush).
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       sb_set_en,
  input  logic [ADDR_W-1:0]          sb_set_addr,
  input  logic                       sb_flush
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;

    // Ascending port order makes the highest-numbered port win a collision.
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        if (!(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == '0)) begin
          regs_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
        end
        busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end

    // A reservation made in the same cycle as a writeback belongs to a
    // younger instruction, so it overrides the clear; flush overrides both.
    if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0)) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    if (sb_flush) begin
      busy_d = '0;
    end

    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end

    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_d[i*DATA_W +: DATA_W] = regs_d[rd_addr[i*ADDR_W +: ADDR_W]];
      rd_busy_d[i]                  = busy_d[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule
